l1_bus_unit: RTL and testbench



---
 rtl/l1_bus_unit_pkg.sv | 24 ++
 rtl/l1_bus_unit.sv | 246 ++++++++++++++++++++++++
 tb/tb_l1_bus_unit.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_bus_unit_pkg.sv
// Shared CPU bus definitions: bus-unit FSM states, access size codes and the
// beat-index width helper used by the L1 bus unit.
package l1_bus_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WT   = 3'd1,
        ST_RD   = 3'd2,
        ST_LINE = 3'd3,
        ST_DONE = 3'd4
    } bus_state_e;

    localparam logic [3:0] SZ_B = 4'd1;
    localparam logic [3:0] SZ_H = 4'd2;
    localparam logic [3:0] SZ_W = 4'd4;
    localparam logic [3:0] SZ_D = 4'd8;

    localparam int BEAT_BYTES = 8;

    function automatic int beat_idx_w(input int line_bytes);
        return $clog2(line_bytes / BEAT_BYTES);
    endfunction

endpackage

// File: rtl/l1_bus_unit.sv
// L1 bus unit: runs one arbitrated write-through, single read or line fill on the
// req/ack master bus and closes it with exactly one trans_rdy or bus_error pulse.
module l1_bus_unit
    import l1_bus_unit_pkg::*;
#(
    parameter int LINE_BYTES = 64,
    parameter int TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        write_through_req,
    input  logic        read_req,
    input  logic        read_line_req,
    input  logic [3:0]  size,
    input  logic [63:0] pa,
    input  logic [63:0] wt_data,
    output logic [63:0] line_data,
    output logic [10:0] addr_count,
    output logic        line_write,
    output logic        cache_entry_write,
    output logic        trans_rdy,
    output logic        bus_error,
    output logic        m_req,
    output logic        m_we,
    output logic [63:0] m_addr,
    output logic [3:0]  m_size,
    output logic [63:0] m_wdata,
    input  logic [63:0] m_rdata,
    input  logic        m_ack,
    input  logic        m_err
);

    localparam int                BEAT_W    = beat_idx_w(LINE_BYTES);
    localparam int                TMO_W     = $clog2(TIMEOUT + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BYTES / BEAT_BYTES - 1);
    localparam logic [TMO_W-1:0]  TMO_LIM   = TMO_W'(TIMEOUT);
    localparam logic [63:0]       LINE_MASK = ~(64'(LINE_BYTES) - 64'd1);

    bus_state_e        r_state;
    logic [BEAT_W-1:0] r_beat;
    logic [TMO_W-1:0]  r_tmo;
    logic              r_m_req;
    logic              r_m_we;
    logic [63:0]       r_m_addr;
    logic [3:0]        r_m_size;
    logic [63:0]       r_m_wdata;
    logic [63:0]       r_line_data;
    logic [10:0]       r_addr_count;
    logic              r_line_write;
    logic              r_cache_entry_write;
    logic              r_trans_rdy;
    logic              r_bus_error;

    bus_state_e        w_state_nx;
    logic [BEAT_W-1:0] w_beat_nx;
    logic [TMO_W-1:0]  w_tmo_nx;
    logic              w_m_req_nx;
    logic              w_m_we_nx;
    logic [63:0]       w_m_addr_nx;
    logic [3:0]        w_m_size_nx;
    logic [63:0]       w_m_wdata_nx;
    logic [63:0]       w_line_data_nx;
    logic [10:0]       w_addr_count_nx;
    logic              w_line_write_nx;
    logic              w_cache_entry_write_nx;
    logic              w_trans_rdy_nx;
    logic              w_bus_error_nx;

    logic              w_tmo_hit;
    logic              w_fail;
    logic              w_ack;

    // An ack arriving in the expiry cycle still counts; m_err beats a simultaneous ack.
    assign w_tmo_hit = r_m_req && (r_tmo == TMO_LIM) && !m_ack;
    assign w_fail    = r_m_req && (m_err || w_tmo_hit);
    assign w_ack     = r_m_req && m_ack && !m_err;

    // Next-state and next-output decode for the transaction FSM.
    always_comb begin
        w_state_nx             = r_state;
        w_beat_nx              = r_beat;
        w_tmo_nx               = r_tmo;
        w_m_req_nx             = r_m_req;
        w_m_we_nx              = r_m_we;
        w_m_addr_nx            = r_m_addr;
        w_m_size_nx            = r_m_size;
        w_m_wdata_nx           = r_m_wdata;
        w_line_data_nx         = r_line_data;
        w_addr_count_nx        = r_addr_count;
        w_line_write_nx        = 1'b0;
        w_cache_entry_write_nx = 1'b0;
        w_trans_rdy_nx         = 1'b0;
        w_bus_error_nx         = 1'b0;

        if (r_m_req && (r_tmo != TMO_LIM)) begin
            w_tmo_nx = r_tmo + TMO_W'(1'b1);
        end else begin
            w_tmo_nx = r_tmo;
        end

        case (r_state)
            ST_IDLE: begin
                if (write_through_req) begin
                    w_state_nx   = ST_WT;
                    w_m_req_nx   = 1'b1;
                    w_m_we_nx    = 1'b1;
                    w_m_addr_nx  = pa;
                    w_m_size_nx  = size;
                    w_m_wdata_nx = wt_data;
                    w_tmo_nx     = '0;
                    w_beat_nx    = '0;
                end else if (read_line_req) begin
                    w_state_nx   = ST_LINE;
                    w_m_req_nx   = 1'b1;
                    w_m_we_nx    = 1'b0;
                    w_m_addr_nx  = pa & LINE_MASK;
                    w_m_size_nx  = SZ_D;
                    w_m_wdata_nx = wt_data;
                    w_tmo_nx     = '0;
                    w_beat_nx    = '0;
                end else if (read_req) begin
                    w_state_nx   = ST_RD;
                    w_m_req_nx   = 1'b1;
                    w_m_we_nx    = 1'b0;
                    w_m_addr_nx  = pa;
                    w_m_size_nx  = size;
                    w_m_wdata_nx = wt_data;
                    w_tmo_nx     = '0;
                    w_beat_nx    = '0;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_WT: begin
                if (w_fail) begin
                    w_state_nx     = ST_DONE;
                    w_m_req_nx     = 1'b0;
                    w_bus_error_nx = 1'b1;
                end else if (w_ack) begin
                    w_state_nx     = ST_DONE;
                    w_m_req_nx     = 1'b0;
                    w_trans_rdy_nx = 1'b1;
                    w_tmo_nx       = '0;
                end else begin
                    w_state_nx = ST_WT;
                end
            end
            ST_RD: begin
                if (w_fail) begin
                    w_state_nx     = ST_DONE;
                    w_m_req_nx     = 1'b0;
                    w_bus_error_nx = 1'b1;
                end else if (w_ack) begin
                    w_state_nx      = ST_DONE;
                    w_m_req_nx      = 1'b0;
                    w_trans_rdy_nx  = 1'b1;
                    w_line_data_nx  = m_rdata;
                    w_addr_count_nx = 11'd0;
                    w_tmo_nx        = '0;
                end else begin
                    w_state_nx = ST_RD;
                end
            end
            ST_LINE: begin
                if (w_fail) begin
                    w_state_nx     = ST_DONE;
                    w_m_req_nx     = 1'b0;
                    w_bus_error_nx = 1'b1;
                end else if (w_ack) begin
                    w_line_data_nx  = m_rdata;
                    w_addr_count_nx = {{(11 - BEAT_W){1'b0}}, r_beat};
                    w_line_write_nx = 1'b1;
                    w_tmo_nx        = '0;
                    if (r_beat == LAST_BEAT) begin
                        w_state_nx             = ST_DONE;
                        w_m_req_nx             = 1'b0;
                        w_trans_rdy_nx         = 1'b1;
                        w_cache_entry_write_nx = 1'b1;
                    end else begin
                        w_state_nx  = ST_LINE;
                        w_beat_nx   = r_beat + BEAT_W'(1'b1);
                        w_m_addr_nx = r_m_addr + 64'd8;
                    end
                end else begin
                    w_state_nx = ST_LINE;
                end
            end
            ST_DONE: begin
                // Absorbs the cycle in which the mux drops its grant.
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_m_req_nx = 1'b0;
            end
        endcase
    end

    // State, counters and all bus/cache outputs registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state             <= ST_IDLE;
            r_beat              <= '0;
            r_tmo               <= '0;
            r_m_req             <= 1'b0;
            r_m_we              <= 1'b0;
            r_m_addr            <= 64'd0;
            r_m_size            <= 4'd0;
            r_m_wdata           <= 64'd0;
            r_line_data         <= 64'd0;
            r_addr_count        <= 11'd0;
            r_line_write        <= 1'b0;
            r_cache_entry_write <= 1'b0;
            r_trans_rdy         <= 1'b0;
            r_bus_error         <= 1'b0;
        end else begin
            r_state             <= w_state_nx;
            r_beat              <= w_beat_nx;
            r_tmo               <= w_tmo_nx;
            r_m_req             <= w_m_req_nx;
            r_m_we              <= w_m_we_nx;
            r_m_addr            <= w_m_addr_nx;
            r_m_size            <= w_m_size_nx;
            r_m_wdata           <= w_m_wdata_nx;
            r_line_data         <= w_line_data_nx;
            r_addr_count        <= w_addr_count_nx;
            r_line_write        <= w_line_write_nx;
            r_cache_entry_write <= w_cache_entry_write_nx;
            r_trans_rdy         <= w_trans_rdy_nx;
            r_bus_error         <= w_bus_error_nx;
        end
    end

    assign line_data         = r_line_data;
    assign addr_count        = r_addr_count;
    assign line_write        = r_line_write;
    assign cache_entry_write = r_cache_entry_write;
    assign trans_rdy         = r_trans_rdy;
    assign bus_error         = r_bus_error;
    assign m_req             = r_m_req;
    assign m_we              = r_m_we;
    assign m_addr            = r_m_addr;
    assign m_size            = r_m_size;
    assign m_wdata           = r_m_wdata;

endmodule

// File: tb/tb_l1_bus_unit.sv
// Directed self-checking bench for l1_bus_unit (LINE_BYTES=64, TIMEOUT=15):
// inputs driven and outputs checked on the falling clock edge.
module tb_l1_bus_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_through_req;
    logic        read_req;
    logic        read_line_req;
    logic [3:0]  size;
    logic [63:0] pa;
    logic [63:0] wt_data;
    logic [63:0] line_data;
    logic [10:0] addr_count;
    logic        line_write;
    logic        cache_entry_write;
    logic        trans_rdy;
    logic        bus_error;
    logic        m_req;
    logic        m_we;
    logic [63:0] m_addr;
    logic [3:0]  m_size;
    logic [63:0] m_wdata;
    logic [63:0] m_rdata;
    logic        m_ack;
    logic        m_err;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_tr   = 0;
    int cnt_be   = 0;
    int cnt_lw   = 0;
    int cnt_cew  = 0;
    int s_tr, s_be, s_lw, s_cew;

    always #5 clk = ~clk;

    l1_bus_unit #(
        .LINE_BYTES(64),
        .TIMEOUT   (15)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .write_through_req(write_through_req),
        .read_req         (read_req),
        .read_line_req    (read_line_req),
        .size             (size),
        .pa               (pa),
        .wt_data          (wt_data),
        .line_data        (line_data),
        .addr_count       (addr_count),
        .line_write       (line_write),
        .cache_entry_write(cache_entry_write),
        .trans_rdy        (trans_rdy),
        .bus_error        (bus_error),
        .m_req            (m_req),
        .m_we             (m_we),
        .m_addr           (m_addr),
        .m_size           (m_size),
        .m_wdata          (m_wdata),
        .m_rdata          (m_rdata),
        .m_ack            (m_ack),
        .m_err            (m_err)
    );

    // Pulse counters: a pulse is counted at the rising edge that ends its cycle.
    always @(posedge clk) begin
        if (trans_rdy)         cnt_tr  <= cnt_tr + 1;
        if (bus_error)         cnt_be  <= cnt_be + 1;
        if (line_write)        cnt_lw  <= cnt_lw + 1;
        if (cache_entry_write) cnt_cew <= cnt_cew + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_tr  = cnt_tr;
        s_be  = cnt_be;
        s_lw  = cnt_lw;
        s_cew = cnt_cew;
    endtask

    // Directed sequence.
    initial begin
        rst = 1'b1; write_through_req = 1'b0; read_req = 1'b0; read_line_req = 1'b0;
        size = 4'd0; pa = 64'd0; wt_data = 64'd0; m_rdata = 64'd0; m_ack = 1'b0; m_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_req", 64'(m_req), 64'd0);
        chk("rst_trans_rdy", 64'(trans_rdy), 64'd0);
        chk("rst_line_data", line_data, 64'd0);
        chk("rst_addr_count", 64'(addr_count), 64'd0);
        chk("rst_m_addr", m_addr, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Write-through, ack three cycles after request.
        write_through_req = 1'b1; pa = 64'h8000_0010; size = 4'd4; wt_data = 64'h1122_3344_5566_7788;
        snap();
        @(negedge clk);
        chk("wt_m_req", 64'(m_req), 64'd1);
        chk("wt_m_we", 64'(m_we), 64'd1);
        chk("wt_m_addr", m_addr, 64'h8000_0010);
        chk("wt_m_size", 64'(m_size), 64'd4);
        chk("wt_m_wdata", m_wdata, 64'h1122_3344_5566_7788);
        @(negedge clk);
        chk("wt_wait_m_req", 64'(m_req), 64'd1);
        chk("wt_wait_trans_rdy", 64'(trans_rdy), 64'd0);
        @(negedge clk);
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        chk("wt_trans_rdy", 64'(trans_rdy), 64'd1);
        chk("wt_m_req_fall", 64'(m_req), 64'd0);
        chk("wt_bus_error", 64'(bus_error), 64'd0);
        write_through_req = 1'b0;
        @(negedge clk);
        chk("wt_trans_rdy_low", 64'(trans_rdy), 64'd0);
        @(negedge clk);
        chk("wt_tr_count", 64'(cnt_tr - s_tr), 64'd1);
        chk("wt_lw_count", 64'(cnt_lw - s_lw), 64'd0);
        chk("wt_idle_m_req", 64'(m_req), 64'd0);

        // Line fill from an unaligned address, ack every cycle.
        read_line_req = 1'b1; pa = 64'h1038;
        snap();
        @(negedge clk);
        chk("line_m_req", 64'(m_req), 64'd1);
        chk("line_m_size", 64'(m_size), 64'd8);
        chk("line_m_we", 64'(m_we), 64'd0);
        m_ack = 1'b1;
        for (int b = 0; b < 8; b++) begin
            chk("line_m_addr", m_addr, 64'h1000 + 64'(8 * b));
            m_rdata = 64'(b) * 64'h11;
            @(negedge clk);
            chk("line_line_write", 64'(line_write), 64'd1);
            chk("line_addr_count", 64'(addr_count), 64'(b));
            chk("line_line_data", line_data, 64'(b) * 64'h11);
            chk("line_trans_rdy", 64'(trans_rdy), 64'(b == 7));
            chk("line_cache_entry_write", 64'(cache_entry_write), 64'(b == 7));
            chk("line_m_req_hold", 64'(m_req), 64'(b != 7));
        end
        m_ack = 1'b0; read_line_req = 1'b0;
        @(negedge clk);
        chk("line_after_lw", 64'(line_write), 64'd0);
        chk("line_after_cew", 64'(cache_entry_write), 64'd0);
        chk("line_hold_data", line_data, 64'h77);
        chk("line_lw_count", 64'(cnt_lw - s_lw), 64'd8);
        chk("line_cew_count", 64'(cnt_cew - s_cew), 64'd1);
        chk("line_tr_count", 64'(cnt_tr - s_tr), 64'd1);

        // Single read failing with m_err; request held so DONE/IDLE timing shows on m_req.
        read_req = 1'b1; pa = 64'h2000; size = 4'd8;
        snap();
        @(negedge clk);
        chk("rderr_m_req", 64'(m_req), 64'd1);
        chk("rderr_m_we", 64'(m_we), 64'd0);
        m_err = 1'b1;
        @(negedge clk);
        m_err = 1'b0;
        chk("rderr_bus_error", 64'(bus_error), 64'd1);
        chk("rderr_trans_rdy", 64'(trans_rdy), 64'd0);
        chk("rderr_line_write", 64'(line_write), 64'd0);
        chk("rderr_m_req_fall", 64'(m_req), 64'd0);
        @(negedge clk);
        chk("rderr_done_ignores_req", 64'(m_req), 64'd0);
        chk("rderr_bus_error_once", 64'(bus_error), 64'd0);
        @(negedge clk);
        chk("rderr_reaccept", 64'(m_req), 64'd1);
        chk("rderr_be_count", 64'(cnt_be - s_be), 64'd1);
        chk("rderr_tr_count", 64'(cnt_tr - s_tr), 64'd0);
        chk("rderr_lw_count", 64'(cnt_lw - s_lw), 64'd0);
        m_ack = 1'b1; m_rdata = 64'hDEAD_BEEF_0123_4567;
        @(negedge clk);
        m_ack = 1'b0; read_req = 1'b0;
        chk("rd_trans_rdy", 64'(trans_rdy), 64'd1);
        chk("rd_line_data", line_data, 64'hDEAD_BEEF_0123_4567);
        chk("rd_addr_count", 64'(addr_count), 64'd0);
        chk("rd_no_line_write", 64'(line_write), 64'd0);
        @(negedge clk);

        // Line fill with ack withheld at beat 3: timeout after 16 idle cycles.
        read_line_req = 1'b1; pa = 64'h4000;
        snap();
        @(negedge clk);
        m_ack = 1'b1;
        for (int b = 0; b < 3; b++) begin
            m_rdata = 64'h100 + 64'(b);
            @(negedge clk);
        end
        m_ack = 1'b0;
        chk("to_beat2_addr_count", 64'(addr_count), 64'd2);
        chk("to_m_addr_beat3", m_addr, 64'h4018);
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            chk("to_wait_bus_error", 64'(bus_error), 64'd0);
            chk("to_wait_m_req", 64'(m_req), 64'd1);
        end
        @(negedge clk);
        chk("to_bus_error", 64'(bus_error), 64'd1);
        chk("to_m_req_fall", 64'(m_req), 64'd0);
        chk("to_cache_entry_write", 64'(cache_entry_write), 64'd0);
        read_line_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("to_be_count", 64'(cnt_be - s_be), 64'd1);
        chk("to_cew_count", 64'(cnt_cew - s_cew), 64'd0);
        chk("to_tr_count", 64'(cnt_tr - s_tr), 64'd0);
        chk("to_lw_count", 64'(cnt_lw - s_lw), 64'd3);

        // Write and read requested together: write first, then the read.
        write_through_req = 1'b1; read_req = 1'b1; pa = 64'h3000; size = 4'd2; wt_data = 64'hCAFE;
        @(negedge clk);
        chk("prio_m_we", 64'(m_we), 64'd1);
        chk("prio_m_size", 64'(m_size), 64'd2);
        m_ack = 1'b1;
        @(negedge clk);
        m_ack = 1'b0;
        chk("prio_wt_trans_rdy", 64'(trans_rdy), 64'd1);
        write_through_req = 1'b0;
        @(negedge clk);
        chk("prio_idle_m_req", 64'(m_req), 64'd0);
        @(negedge clk);
        chk("prio_rd_m_req", 64'(m_req), 64'd1);
        chk("prio_rd_m_we", 64'(m_we), 64'd0);
        m_ack = 1'b1; m_rdata = 64'h55;
        @(negedge clk);
        m_ack = 1'b0; read_req = 1'b0;
        chk("prio_rd_trans_rdy", 64'(trans_rdy), 64'd1);
        chk("prio_rd_line_data", line_data, 64'h55);
        @(negedge clk);

        // Reset in the middle of a line fill, at beat 5.
        read_line_req = 1'b1; pa = 64'h5000;
        snap();
        @(negedge clk);
        m_ack = 1'b1;
        for (int b = 0; b < 5; b++) begin
            m_rdata = 64'h200 + 64'(b);
            @(negedge clk);
        end
        m_ack = 1'b0;
        chk("rstmid_m_addr_beat5", m_addr, 64'h5028);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_m_req", 64'(m_req), 64'd0);
        chk("rstmid_line_write", 64'(line_write), 64'd0);
        chk("rstmid_line_data", line_data, 64'd0);
        chk("rstmid_addr_count", 64'(addr_count), 64'd0);
        chk("rstmid_m_addr", m_addr, 64'd0);
        chk("rstmid_trans_rdy", 64'(trans_rdy), 64'd0);
        read_line_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rstmid_tr_count", 64'(cnt_tr - s_tr), 64'd0);
        chk("rstmid_be_count", 64'(cnt_be - s_be), 64'd0);
        chk("rstmid_cew_count", 64'(cnt_cew - s_cew), 64'd0);
        chk("rstmid_lw_count", 64'(cnt_lw - s_lw), 64'd5);

        // m_err together with m_ack on beat 1 of a line fill.
        read_line_req = 1'b1; pa = 64'h6000;
        snap();
        @(negedge clk);
        m_ack = 1'b1; m_rdata = 64'hAAAA;
        @(negedge clk);
        m_err = 1'b1; m_rdata = 64'hBBBB;
        @(negedge clk);
        m_ack = 1'b0; m_err = 1'b0;
        chk("errack_bus_error", 64'(bus_error), 64'd1);
        chk("errack_line_write", 64'(line_write), 64'd0);
        chk("errack_line_data_hold", line_data, 64'hAAAA);
        chk("errack_addr_count_hold", 64'(addr_count), 64'd0);
        chk("errack_cache_entry_write", 64'(cache_entry_write), 64'd0);
        chk("errack_m_req_fall", 64'(m_req), 64'd0);
        read_line_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("errack_lw_count", 64'(cnt_lw - s_lw), 64'd1);
        chk("errack_be_count", 64'(cnt_be - s_be), 64'd1);
        chk("errack_tr_count", 64'(cnt_tr - s_tr), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
